// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR sequencer/configurator.
//   state_t    : job sequencing states
//   FIFO_DEPTH : depth of the result buffer, which is also the credit limit
//   MAX_LEN    : largest output length the 16-bit counters can represent
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    RUN,
    DRAIN,
    FLUSH
  } state_t;

  localparam int FIFO_DEPTH = 2;

  localparam logic [15:0] MAX_LEN = 16'hFFFF;

endpackage

// File: rtl/fir_res_fifo.sv
// Two-entry first-word-fall-through FIFO that buffers filter results.
//   i_clk, i_reset : clock, synchronous active-high reset
//   wr_en, wr_data : push one result
//   rd_en          : pop the head (ignored while empty)
//   rd_data        : head entry, valid while rd_valid is high
//   rd_valid       : FIFO not empty
//   count          : current occupancy, 0..FIFO_DEPTH
module fir_res_fifo
  import fir_ctrl_pkg::*;
#(
  parameter int W = 31
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic [1:0]   count
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         do_rd;
  logic         do_wr;

  assign do_rd = rd_en && (count != 2'd0);
  // A push into a full FIFO is allowed only when the head leaves in the same cycle.
  assign do_wr = wr_en && ((count != FULL) || do_rd);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count  <= 2'd0;
      // NOTE: the two storage words are reset as well; with only two entries this
      // is cheap and keeps rd_data at 0 instead of X straight after reset.
      head_q <= '0;
      tail_q <= '0;
    end else begin
      // NOTE: every register in a clocked block is assigned with <= so all of them
      // update together from the pre-edge values.
      unique case ({do_wr, do_rd})
        2'b10: begin
          if (count == 2'd0) head_q <= wr_data;
          else               tail_q <= wr_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_q <= wr_data;
          end else begin
            head_q <= tail_q;
            tail_q <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_data  = head_q;
  assign rd_valid = (count != 2'd0);

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer/configurator for one FIR datapath instance.
// Holds a shadow tap bank; per job it loads taps/ntaps/output length into the
// filter, clears its delay line, streams in_len samples followed by ntaps-1
// zeros, and returns in_len+ntaps-1 results on a backpressured stream.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_cfg_tap_*             : shadow tap write (IDLE only, idx 0..NTAPS)
//   i_cfg_ntaps, i_cfg_in_len, i_start : job configuration and start pulse
//   o_busy, o_done, o_err   : job status (o_err sticky on illegal start)
//   s_valid/s_data/s_ready  : input sample stream
//   m_valid/m_data/m_ready  : result stream
//   o_fir_*                 : filter control; i_fir_result arrives one cycle after o_fir_ce
module fir_seq_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int IW    = 12,
  parameter int TW    = 12,
  parameter int OW    = 31
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_cfg_tap_we,
  input  logic [3:0]              i_cfg_tap_idx,
  input  logic [TW-1:0]           i_cfg_tap_data,
  input  logic [3:0]              i_cfg_ntaps,
  input  logic [15:0]             i_cfg_in_len,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  input  logic                    s_valid,
  input  logic [IW-1:0]           s_data,
  output logic                    s_ready,
  output logic                    m_valid,
  output logic [OW-1:0]           m_data,
  input  logic                    m_ready,
  output logic                    o_fir_reset,
  output logic                    o_fir_ce,
  output logic [IW-1:0]           o_fir_sample,
  output logic                    o_fir_tap_wr,
  output logic [NTAPS:0][TW-1:0]  o_fir_new_tap,
  output logic [3:0]              o_fir_ntaps,
  output logic                    o_fir_ntaps_en,
  output logic [15:0]             o_fir_output_lenght,
  input  logic [OW-1:0]           i_fir_result
);

  localparam logic [3:0] NTAPS_L = 4'(NTAPS);

  state_t      state;
  logic [15:0] in_len_q;
  logic [15:0] in_cnt;
  logic [3:0]  drain_left;
  logic        pend;          // a ce was issued last cycle; its result lands this cycle
  logic [1:0]  fifo_count;
  logic [2:0]  owed;
  logic        pop;
  logic        slot;
  logic        run_fire;
  logic        drain_fire;
  logic        flush_done;
  logic [16:0] len_sum;
  logic        start_ok;

  // Legality of a start request; the 17-bit sum catches lengths beyond 16 bits.
  assign len_sum  = {1'b0, i_cfg_in_len} + {13'd0, i_cfg_ntaps} - 17'd1;
  assign start_ok = (i_cfg_ntaps != 4'd0) && (i_cfg_ntaps <= NTAPS_L) &&
                    (i_cfg_in_len != 16'd0) && (len_sum <= {1'b0, MAX_LEN});

  // Credit: results owed = buffered + in flight, capped at the FIFO depth.
  // A pop this cycle frees a place for the result of a ce issued now.
  assign pop  = m_valid && m_ready;
  assign owed = {1'b0, fifo_count} + {2'b00, pend};
  assign slot = (owed < 3'(FIFO_DEPTH)) || pop;

  assign run_fire   = (state == RUN) && s_valid && slot;
  assign drain_fire = (state == DRAIN) && (drain_left != 4'd0) && slot;
  assign flush_done = (state == FLUSH) && !pend &&
                      ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

  // Handshake-dependent outputs must follow the same-cycle stream state, so they
  // are decoded combinationally from registered state and live inputs.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    s_ready      = 1'b0;
    o_fir_ce     = 1'b0;
    o_fir_sample = '0;
    if (state == RUN) begin
      s_ready      = slot;
      o_fir_ce     = run_fire;
      o_fir_sample = s_data;
    end else if (state == DRAIN) begin
      o_fir_ce = drain_fire;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state               <= IDLE;
      o_busy              <= 1'b0;
      o_done              <= 1'b0;
      o_err               <= 1'b0;
      o_fir_reset         <= 1'b0;
      o_fir_tap_wr        <= 1'b0;
      o_fir_ntaps_en      <= 1'b0;
      o_fir_ntaps         <= 4'd0;
      o_fir_output_lenght <= 16'd0;
      o_fir_new_tap       <= '0;
      in_len_q            <= 16'd0;
      in_cnt              <= 16'd0;
      drain_left          <= 4'd0;
      pend                <= 1'b0;
    end else begin
      o_fir_reset    <= 1'b0;
      o_fir_tap_wr   <= 1'b0;
      o_fir_ntaps_en <= 1'b0;
      o_done         <= 1'b0;
      pend           <= o_fir_ce;

      unique case (state)
        IDLE: begin
          // The shadow bank drives the filter directly, so a write in the start
          // cycle is already visible when the CONFIG strobes fire.
          if (i_cfg_tap_we && (i_cfg_tap_idx <= NTAPS_L)) begin
            o_fir_new_tap[i_cfg_tap_idx] <= i_cfg_tap_data;
          end
          if (i_start) begin
            if (start_ok) begin
              o_fir_ntaps         <= i_cfg_ntaps;
              o_fir_output_lenght <= len_sum[15:0];
              in_len_q            <= i_cfg_in_len;
              o_err               <= 1'b0;
              o_busy              <= 1'b1;
              o_fir_reset         <= 1'b1;
              o_fir_tap_wr        <= 1'b1;
              o_fir_ntaps_en      <= 1'b1;
              state               <= CONFIG;
            end else begin
              o_err <= 1'b1;
            end
          end
        end

        CONFIG: begin
          in_cnt     <= 16'd0;
          drain_left <= o_fir_ntaps - 4'd1;
          state      <= RUN;
        end

        RUN: begin
          if (run_fire) begin
            in_cnt <= in_cnt + 16'd1;
            if (in_cnt == in_len_q - 16'd1) state <= DRAIN;
          end
        end

        DRAIN: begin
          if (drain_left == 4'd0) begin
            state <= FLUSH;
          end else if (drain_fire) begin
            drain_left <= drain_left - 4'd1;
            if (drain_left == 4'd1) state <= FLUSH;
          end
        end

        FLUSH: begin
          if (flush_done) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  fir_res_fifo #(.W(OW)) u_res_fifo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .wr_en    (pend),
    .wr_data  (i_fir_result),
    .rd_en    (m_ready),
    .rd_data  (m_data),
    .rd_valid (m_valid),
    .count    (fifo_count)
  );

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
Sequencer and configurator for one generic FIR datapath instance. It holds a shadow tap bank, then per job pushes taps, tap count and output length into the filter and clears its delay line. It feeds cfg_in_len samples from a valid/ready stream plus ntaps-1 zero samples to flush the pipeline, and returns all in_len+ntaps-1 convolution results on a backpressured output stream.

Parameters:
NTAPS, 8, maximum tap count of the attached filter
IW, 12, sample width
TW, 12, tap width
OW, 31, result width (2*IW+7)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_cfg_tap_we  in  1  write shadow tap (accepted only in IDLE)
i_cfg_tap_idx  in  4  shadow tap index, 0..NTAPS
i_cfg_tap_data  in  TW  shadow tap value
i_cfg_ntaps  in  4  taps for the job, legal 1..NTAPS
i_cfg_in_len  in  16  input samples for the job, legal >=1
i_start  in  1  start pulse (accepted only in IDLE)
o_busy  out  1  high from accepted start until o_done
o_done  out  1  1-cycle pulse at job end
o_err  out  1  sticky illegal-start flag; cleared by the next legal start or reset
s_valid  in  1  input sample valid
s_data  in  IW  input sample
s_ready  out  1  input sample accepted when s_valid&&s_ready
m_valid  out  1  result valid
m_data  out  OW  result
m_ready  in  1  result accepted when m_valid&&m_ready
o_fir_reset  out  1  filter delay-line clear
o_fir_ce  out  1  filter shift enable
o_fir_sample  out  IW  filter sample input
o_fir_tap_wr  out  1  filter tap load strobe
o_fir_new_tap  out  [NTAPS:0]xTW  shadow tap bank, driven continuously
o_fir_ntaps  out  4  latched ntaps
o_fir_ntaps_en  out  1  ntaps load strobe
o_fir_output_lenght  out  16  in_len+ntaps-1
i_fir_result  in  OW  filter result

Behaviour:
- Reset: all outputs 0; shadow taps 0; FSM IDLE; counters and output FIFO cleared.
- FSM IDLE -> CONFIG -> RUN -> DRAIN -> FLUSH -> IDLE.
- IDLE: taps writable; i_cfg_tap_idx > NTAPS is ignored.
  - i_start with ntaps in 1..NTAPS and in_len != 0: latch config, clear o_err, go to CONFIG.
  - Any other i_start: set o_err and stay IDLE.
  - i_start and i_cfg_tap_we in the same cycle: the tap write lands first, and CONFIG sees the new value.
- CONFIG (exactly 1 cycle): o_fir_tap_wr = o_fir_ntaps_en = o_fir_reset = 1; go to RUN.
- Credit rule: at most 2 results may be owed at any time, counting FIFO entries plus in-flight. An "accept slot" exists when FIFO occupancy + inflight < 2, or when m_ready pops an entry this cycle.
- RUN:
  - s_ready = accept slot.
  - On s_valid&&s_ready: o_fir_ce=1, o_fir_sample=s_data, in_cnt++.
  - After in_cnt reaches in_len: go to DRAIN with s_ready=0 in the same cycle.
- DRAIN: issue ntaps-1 ce pulses with o_fir_sample=0, each gated by the credit rule. If ntaps==1, pass through DRAIN in 1 cycle with no pulses. Then go to FLUSH.
- Result capture: i_fir_result is written into the 2-entry output FIFO in the cycle after each o_fir_ce. The first-word-fall-through head drives m_data/m_valid.
- FLUSH: wait until FIFO is empty and nothing is in flight; pulse o_done and return to IDLE. o_busy drops in the same cycle o_done fires.
- Full throughput: 1 result/cycle when m_ready=1 and s_valid=1.
- m_ready=0: ce stalls after 2 results are owed; no result is ever dropped or duplicated.
- Total m transfers per job = in_len + ntaps - 1.
- i_reset mid-job: abort to IDLE next edge, FIFO emptied, no o_done. Shadow taps also reset.
- Counters are 16-bit. in_len + ntaps - 1 > 65535 is flagged as o_err at start and the job is not run.

Decomposition:
- Package fir_ctrl_pkg holds:
  - state enum (IDLE, CONFIG, RUN, DRAIN, FLUSH);
  - localparam FIFO_DEPTH=2;
  - constant MAX_LEN=16'hFFFF.
- Sub-module fir_res_fifo: 2-entry FWFT FIFO with count output, used for the output buffer.

Test Plan:
- Taps {1,2,3} (ntaps=3), in_len=4, samples 1,2,3,4, m_ready=1 -> 6 results 1,4,10,16,17,12; o_done 1 cycle after last transfer; o_fir_tap_wr only in CONFIG.
- Same job with m_ready toggling 1/0 every cycle -> identical 6 values, in order; never more than 2 ce pulses ahead of pops.
- ntaps=1 tap {5}, in_len=3, samples 1,2,3 -> results 5,10,15; zero DRAIN ce pulses.
- i_start with ntaps=0, then with ntaps=9, then with in_len=0 -> o_err=1 each time, busy stays 0, no fir strobes.
- i_reset asserted during RUN after 2 samples -> next cycle all outputs 0, m_valid=0, no o_done; a new job then completes correctly.
- Back-to-back jobs with different taps ({1,1} then {2}) -> second job's results use only the new taps and the delay line was cleared (first result = 2*s0).
